// File: rtl/axis_adc_ddr_capture.sv
// axis_adc_ddr_capture: DDR ADC capture with per-channel ramp lock/error checking
// and a never-stalling AXI4-Stream output whose drops are flagged by overrun.
module axis_adc_ddr_capture #(
  parameter int NUM_CHANNELS   = 2,
  parameter int DDR_DATA_WIDTH = 7,
  parameter int LANE_WIDTH     = 16,
  parameter int LOCK_COUNT     = 64,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [NUM_CHANNELS*DDR_DATA_WIDTH-1:0] adc_dat_in,
  input  logic [NUM_CHANNELS-1:0]                edge_swap,
  input  logic                                   pattern_en,
  input  logic                                   err_clr,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tvalid,
  output logic [NUM_CHANNELS*LANE_WIDTH-1:0]     m_axis_tdata,
  output logic [NUM_CHANNELS-1:0]                pattern_locked,
  output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0]  err_count,
  output logic                                   overrun
);
  localparam int SW = 2*DDR_DATA_WIDTH;
  localparam int RW = $clog2(LOCK_COUNT);
  typedef enum logic {SEARCH, LOCKED} state_t;
  logic       w_iddr_rst;
  logic [1:0] r_vld;
  logic       r_ovr;
  assign w_iddr_rst    = ~aresetn;
  assign m_axis_tvalid = r_vld[1];
  assign overrun       = r_ovr;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_vld <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_vld <= {r_vld[0], 1'b1};
      r_ovr <= err_clr ? 1'b0 : (r_ovr | (r_vld[1] & ~m_axis_tready));
    end
  end
  genvar c;
  generate
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [DDR_DATA_WIDTH-1:0] w_pin, r_rise, r_fall, r_q1, r_q2;
      logic [SW-1:0]             w_s, r_s;
      logic                      w_ok, r_prm, r_lock;
      logic [RW-1:0]             r_run;
      logic [ERR_CNT_WIDTH-1:0]  r_err;
      state_t                    r_st;
      assign w_pin = adc_dat_in[c*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
      // Behavioural IDDR in SAME_EDGE_PIPELINED mode: both halves re-registered on the rising edge
      always_ff @(posedge aclk or posedge w_iddr_rst) begin
        if (w_iddr_rst) begin
          r_rise <= '0;
          r_q1   <= '0;
          r_q2   <= '0;
        end else begin
          r_rise <= w_pin;
          r_q1   <= r_rise;
          r_q2   <= r_fall;
        end
      end
      always_ff @(negedge aclk or posedge w_iddr_rst) begin
        if (w_iddr_rst) r_fall <= '0;
        else r_fall <= w_pin;
      end
      always_comb begin
        w_s = '0;
        for (int j = 0; j < DDR_DATA_WIDTH; j++) begin
          w_s[2*j]   = edge_swap[c] ? r_q2[j] : r_q1[j];
          w_s[2*j+1] = edge_swap[c] ? r_q1[j] : r_q2[j];
        end
      end
      // The incoming sample is judged against the one currently held in the output register
      assign w_ok = (w_s == r_s + SW'(1));
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_s    <= '0;
          r_prm  <= 1'b0;
          r_st   <= SEARCH;
          r_run  <= '0;
          r_lock <= 1'b0;
          r_err  <= '0;
        end else begin
          r_s   <= w_s;
          r_prm <= pattern_en;
          if (!pattern_en || (r_prm && !w_ok)) begin
            r_st   <= SEARCH;
            r_run  <= '0;
            r_lock <= 1'b0;
          end else if (r_prm && r_st == SEARCH) begin
            if (r_run == RW'(LOCK_COUNT-1)) begin
              r_st   <= LOCKED;
              r_run  <= '0;
              r_lock <= 1'b1;
            end else r_run <= r_run + RW'(1);
          end
          if (err_clr) r_err <= '0;
          else if (pattern_en && r_prm && !w_ok && r_err != '1) r_err <= r_err + ERR_CNT_WIDTH'(1);
        end
      end
      assign m_axis_tdata[c*LANE_WIDTH +: LANE_WIDTH]     = LANE_WIDTH'(r_s);
      assign pattern_locked[c]                            = r_lock;
      assign err_count[c*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = r_err;
    end
  endgenerate
endmodule

// File: tb/tb_axis_adc_ddr_capture.sv
// tb_axis_adc_ddr_capture: directed ramp/lock/saturation/overrun/reset sequence with hand-computed expectations.
module tb_axis_adc_ddr_capture;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [13:0] adc_dat_in = '0;
  logic [1:0]  edge_swap = '0;
  logic        pattern_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [1:0]  pattern_locked;
  logic [31:0] err_count;
  logic        overrun;
  int vectors = 0;
  int miscompares = 0;

  axis_adc_ddr_capture dut (
    .aclk(aclk), .aresetn(aresetn), .adc_dat_in(adc_dat_in), .edge_swap(edge_swap),
    .pattern_en(pattern_en), .err_clr(err_clr), .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .pattern_locked(pattern_locked),
    .err_count(err_count), .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  function automatic logic [6:0] ev(input logic [13:0] v);
    logic [6:0] r;
    for (int j = 0; j < 7; j++) r[j] = v[2*j];
    return r;
  endfunction

  function automatic logic [6:0] od(input logic [13:0] v);
    logic [6:0] r;
    for (int j = 0; j < 7; j++) r[j] = v[2*j+1];
    return r;
  endfunction

  function automatic logic [13:0] rv(input int k);
    return 14'(16300 + k);
  endfunction

  task automatic cyc(input logic [13:0] v0, input logic [13:0] v1, input logic sw0);
    adc_dat_in = {ev(v1), sw0 ? od(v0) : ev(v0)};
    @(posedge aclk);
    #1;
    adc_dat_in = {od(v1), sw0 ? ev(v0) : od(v0)};
    @(negedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #3;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_locked", 32'(pattern_locked), 32'h0);
    chk("rst_err", err_count, 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    #4 aresetn = 1'b1;
    for (int k = 1; k <= 244; k++) begin
      if (k == 4) pattern_en = 1'b1;
      if (k == 180) edge_swap = 2'b01;
      cyc(rv(k), (k >= 91) ? rv(k) + 14'd1 : rv(k), k >= 158);
      case (k)
        1:   chk("tvalid_edge1", 32'(m_axis_tvalid), 32'h0);
        2:   chk("tvalid_edge2", 32'(m_axis_tvalid), 32'h1);
        3:   chk("tdata_latency", m_axis_tdata, 32'h3FAD_3FAD);
        67:  chk("lock_63_ok", 32'(pattern_locked), 32'h0);
        68:  begin
               chk("lock_64_ok", 32'(pattern_locked), 32'h3);
               chk("err_after_lock", err_count, 32'h0);
             end
        85:  chk("tdata_max", m_axis_tdata, 32'h3FFF_3FFF);
        86:  begin
               chk("tdata_wrap", m_axis_tdata, 32'h0);
               chk("lock_wrap", 32'(pattern_locked), 32'h3);
             end
        90:  begin
               chk("tdata_post_wrap", m_axis_tdata, 32'h0004_0004);
               chk("err_post_wrap", err_count, 32'h0);
             end
        92:  chk("lock_pre_skip", 32'(pattern_locked), 32'h3);
        93:  begin
               chk("lock_skip_ch1", 32'(pattern_locked), 32'h1);
               chk("err_skip_ch1", err_count, 32'h0001_0000);
             end
        95:  chk("tdata_skip", m_axis_tdata, 32'h000A_0009);
        156: chk("relock_63_ok", 32'(pattern_locked), 32'h1);
        157: chk("relock_64_ok", 32'(pattern_locked), 32'h3);
        159: chk("err_pre_swap", err_count, 32'h0001_0000);
        160: begin
               chk("lock_swapped", 32'(pattern_locked), 32'h2);
               chk("err_swapped", err_count, 32'h0001_0001);
             end
        162: chk("tdata_swapped", m_axis_tdata, 32'h004D_008C);
        179: chk("err_climb", err_count, 32'h0001_0014);
        180: chk("err_swap_fix", err_count, 32'h0001_0015);
        243: chk("lock_swap_63", 32'(pattern_locked), 32'h2);
        244: begin
               chk("lock_swap_64", 32'(pattern_locked), 32'h3);
               chk("tdata_unswapped", m_axis_tdata, 32'h009F_009E);
               chk("err_hold", err_count, 32'h0001_0015);
             end
        default: ;
      endcase
    end
    edge_swap = 2'b00;
    repeat (65600) cyc(14'd0, 14'd0, 1'b0);
    chk("err_saturate", err_count, 32'hFFFF_FFFF);
    chk("lock_constant", 32'(pattern_locked), 32'h0);
    err_clr = 1'b1;
    cyc(14'd0, 14'd0, 1'b0);
    err_clr = 1'b0;
    chk("err_clr_wins", err_count, 32'h0);
    cyc(14'd0, 14'd0, 1'b0);
    chk("err_recount", err_count, 32'h0001_0001);
    pattern_en = 1'b0;
    repeat (3) cyc(14'd0, 14'd0, 1'b0);
    chk("err_frozen", err_count, 32'h0001_0001);
    chk("lock_disabled", 32'(pattern_locked), 32'h0);
    chk("overrun_idle", 32'(overrun), 32'h0);
    m_axis_tready = 1'b0;
    cyc(14'd0, 14'd0, 1'b0);
    m_axis_tready = 1'b1;
    chk("overrun_set", 32'(overrun), 32'h1);
    repeat (3) cyc(14'd0, 14'd0, 1'b0);
    chk("overrun_sticky", 32'(overrun), 32'h1);
    err_clr = 1'b1;
    m_axis_tready = 1'b0;
    cyc(14'd0, 14'd0, 1'b0);
    err_clr = 1'b0;
    m_axis_tready = 1'b1;
    chk("overrun_clr_wins", 32'(overrun), 32'h0);
    chk("err_clr_frozen", err_count, 32'h0);
    m_axis_tready = 1'b0;
    cyc(14'd0, 14'd0, 1'b0);
    m_axis_tready = 1'b1;
    repeat (3) cyc(14'd5, 14'd5, 1'b0);
    chk("tdata_pre_reset", m_axis_tdata, 32'h0005_0005);
    chk("overrun_pre_reset", 32'(overrun), 32'h1);
    #2 aresetn = 1'b0;
    #1;
    chk("async_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("async_tdata", m_axis_tdata, 32'h0);
    chk("async_locked", 32'(pattern_locked), 32'h0);
    chk("async_err", err_count, 32'h0);
    chk("async_overrun", 32'(overrun), 32'h0);
    #3 aresetn = 1'b1;
    cyc(14'd5, 14'd5, 1'b0);
    chk("rerun_tvalid_edge1", 32'(m_axis_tvalid), 32'h0);
    cyc(14'd5, 14'd5, 1'b0);
    chk("rerun_tvalid_edge2", 32'(m_axis_tvalid), 32'h1);
    cyc(14'd5, 14'd5, 1'b0);
    chk("rerun_tdata", m_axis_tdata, 32'h0005_0005);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
